// File: rtl/i2c_reg_writer.sv
// I2C register writer: sends one START, the slave address byte (write),
// a register address byte and a data byte, checks each ACK slot, then STOP.
// SCL and SDA are open-drain: the block only ever pulls them low.
module i2c_reg_writer #(
    parameter int unsigned QUARTER_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       ack_err,
    output wire        i2c_scl,
    inout  wire        i2c_sda
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [15:0] QUARTER_LAST = 16'(QUARTER_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;     // counts 7 down to 0, MSB first
    logic [1:0]  byte_idx_q, byte_idx_d;   // 0 = address, 1 = register, 2 = data
    logic [7:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        err_q, err_d;             // NACK seen in the running transaction
    logic        ack_err_q, ack_err_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        scl_low_q, scl_low_d;
    logic        sda_low_q, sda_low_d;

    logic        quarter_end;
    logic        sda_in;
    logic [7:0]  byte_sel;

    assign sda_in      = i2c_sda;
    assign quarter_end = (tick_cnt_q == QUARTER_LAST);

    // Next-state logic; bus drive levels are derived from the next phase so the
    // registered line drivers line up exactly with the registered state.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = 16'd0;
        quarter_d  = quarter_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        data_d     = data_q;
        err_d      = err_q;
        ack_err_d  = ack_err_q;
        byte_sel   = 8'd0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            tick_cnt_d = quarter_end ? 16'd0 : tick_cnt_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && ready_q) begin
                    // Write direction: R/W bit is always 0.
                    dev_d      = dev_addr & 8'hFE;
                    reg_d      = reg_addr;
                    data_d     = data;
                    err_d      = 1'b0;
                    ack_err_d  = 1'b0;
                    quarter_d  = 2'd0;
                    bit_cnt_d  = 3'd7;
                    byte_idx_d = 2'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (quarter_end) begin
                    if (quarter_q == 2'd1) begin
                        quarter_d = 2'd0;
                        state_d   = S_BYTE;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end
            S_BYTE: begin
                if (quarter_end) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d = S_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                // Slave answers while SCL is high; look at it just before SCL
                // enters its second high quarter ends.
                if (quarter_end && quarter_q == 2'd1 && sda_in) begin
                    err_d = 1'b1;
                end
                if (quarter_end) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (err_q || byte_idx_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            bit_cnt_d  = 3'd7;
                            state_d    = S_BYTE;
                        end
                    end
                end
            end
            S_STOP: begin
                if (quarter_end) begin
                    if (quarter_q == 2'd2) begin
                        quarter_d = 2'd0;
                        ack_err_d = err_q;
                        state_d   = S_DONE;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (byte_idx_d)
            2'd0:    byte_sel = dev_d;
            2'd1:    byte_sel = reg_d;
            default: byte_sel = data_d;
        endcase

        ready_d   = (state_d == S_IDLE);
        done_d    = (state_d == S_DONE);
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        unique case (state_d)
            S_START: begin
                sda_low_d = (quarter_d == 2'd1);
            end
            S_BYTE: begin
                // Bit value is constant for the whole bit, so SDA only moves
                // at the q0 boundary while SCL is low.
                scl_low_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_low_d = ~byte_sel[bit_cnt_d];
            end
            S_ACK: begin
                scl_low_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
            end
            S_STOP: begin
                scl_low_d = (quarter_d == 2'd0);
                sda_low_d = (quarter_d != 2'd2);
            end
            default: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
        endcase
    end

    // State, counters, latched operands and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= 16'd0;
            quarter_q  <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            dev_q      <= 8'd0;
            reg_q      <= 8'd0;
            data_q     <= 8'd0;
            err_q      <= 1'b0;
            ack_err_q  <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            quarter_q  <= quarter_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            err_q      <= err_d;
            ack_err_q  <= ack_err_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Bench for i2c_reg_writer: a behavioural I2C slave decodes the bus and
// answers ACK/NACK by plan; expected timing and bytes come from the
// transaction rules (quarter counts, byte list), not from the RTL.
module tb_i2c_reg_writer;
    localparam int QD  = 4;
    localparam int QD2 = 125;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       start2  = 1'b0;
    logic [7:0] dev_addr = 8'd0, reg_addr = 8'd0, data = 8'd0;
    logic       ready, done, ack_err;
    logic       ready2, done2, ack_err2;
    wire        scl, sda, scl2, sda2;

    pullup pu_scl (scl);
    pullup pu_sda (sda);
    pullup pu_scl2 (scl2);
    pullup pu_sda2 (sda2);

    logic sl_drv = 1'b0;
    assign sda = sl_drv ? 1'b0 : 1'bz;

    i2c_reg_writer #(.QUARTER_DIV(QD)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .data(data),
        .ready(ready), .done(done), .ack_err(ack_err),
        .i2c_scl(scl), .i2c_sda(sda)
    );

    // Second instance at the board rate, no slave attached (always NACK).
    i2c_reg_writer #(.QUARTER_DIV(QD2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .data(data),
        .ready(ready2), .done(done2), .ack_err(ack_err2),
        .i2c_scl(scl2), .i2c_sda(sda2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural slave: START/STOP detection, bits on SCL rise, ACK driven
    // from the 8th SCL fall to the 9th SCL fall unless this byte is to be NACKed.
    int         nack_byte = 3;
    int         sl_bits = 0, sl_byte = 0;
    int         n_start = 0, n_stop = 0;
    logic [7:0] sl_sh = 8'd0;
    logic [7:0] rx_q[$];
    logic       scl_p = 1'b1, sda_p = 1'b1;

    always @(posedge clk) begin
        #1;
        if (scl && scl_p && sda_p && !sda) begin
            n_start++;
            sl_bits = 0;
            sl_byte = 0;
            sl_drv  = 1'b0;
        end else if (scl && scl_p && !sda_p && sda) begin
            n_stop++;
            sl_drv = 1'b0;
        end else if (scl && !scl_p) begin
            if (sl_bits < 8) sl_sh = {sl_sh[6:0], sda};
            sl_bits++;
            if (sl_bits == 8) rx_q.push_back(sl_sh);
        end else if (!scl && scl_p) begin
            if (sl_bits == 8) begin
                sl_drv = (nack_byte != sl_byte);
            end else if (sl_bits == 9) begin
                sl_drv  = 1'b0;
                sl_bits = 0;
                sl_byte++;
            end
        end
        scl_p = scl;
        sda_p = sda;
    end

    // One full transaction on u_dut; nk = byte index to NACK (3 = none).
    task automatic run_txn(input logic [7:0] d, input logic [7:0] r, input logic [7:0] x,
                           input int nk, input bit disturb);
        int         c;
        int         n;
        int         exp_cyc;
        logic [7:0] exp_b[3];
        exp_b[0] = d & 8'hFE;
        exp_b[1] = r;
        exp_b[2] = x;
        n        = (nk < 3) ? nk : 2;
        exp_cyc  = (2 + 36 * (n + 1) + 3) * QD + 1;
        nack_byte = nk;
        rx_q.delete();
        n_start = 0;
        n_stop  = 0;

        c = 0;
        while (!ready && c < 2000) begin tick(); c++; end
        chk("rdy_wait", ready, 1);

        start = 1'b1; dev_addr = d; reg_addr = r; data = x;
        tick();
        start = 1'b0;
        dev_addr = 8'($urandom); reg_addr = 8'($urandom); data = 8'($urandom);
        chk("rdy_low", ready, 0);
        chk("err_clr", ack_err, 0);

        c = 1;
        while (!done && c < 1000) begin
            if (disturb && c == 100) begin
                start = 1'b1;
                dev_addr = 8'($urandom); reg_addr = 8'($urandom); data = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
        end
        start = 1'b0;
        chk("done_cyc", c, exp_cyc);
        chk("ack_err", ack_err, (nk < 3) ? 1 : 0);
        chk("n_start", n_start, 1);
        chk("n_stop", n_stop, 1);
        chk("rx_cnt", rx_q.size(), n + 1);
        for (int i = 0; i <= n; i++) begin
            chk("rx_byte", (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_b[i]});
        end
        tick();
        chk("done_pulse", done, 0);
        chk("rdy_back", ready, 1);
        chk("idle_scl", scl, 1);
        chk("idle_sda", sda, 1);
    endtask

    initial begin
        int c;
        int r1, r2;
        logic p2;

        // Reset state
        repeat (3) tick();
        reset_n = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_ackerr", ack_err, 0);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_ready2", ready2, 1);

        // Directed transfers: all ACK, NACK address, NACK data, then
        // ignored mid-transfer start with address bit 0 set (also clears ack_err).
        run_txn(8'h72, 8'h41, 8'h10, 3, 1'b0);
        run_txn(8'h72, 8'h41, 8'h10, 0, 1'b0);
        run_txn(8'h72, 8'h41, 8'h10, 2, 1'b0);
        run_txn(8'h73, 8'h41, 8'h10, 3, 1'b1);

        // Reset in the middle of the register byte
        start = 1'b1; dev_addr = 8'h72; reg_addr = 8'h41; data = 8'h10;
        tick();
        start = 1'b0;
        c = 1;
        while (c < 54 * QD + 3) begin tick(); c++; end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_scl", scl, 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        run_txn(8'h72, 8'h41, 8'h10, 3, 1'b0);

        // Reset wins over start in the same cycle
        reset_n = 1'b0; start = 1'b1;
        tick();
        reset_n = 1'b1; start = 1'b0;
        chk("rst_prio", ready, 1);
        tick();
        chk("rst_prio2", ready, 1);
        chk("rst_prio_scl", scl, 1);

        // Randomized transfers
        for (int i = 0; i < 6; i++) begin
            run_txn(8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Board-rate instance, start held high: SCL period and back-to-back gap
        start2 = 1'b1;
        tick();
        c  = 1;
        r1 = -1;
        r2 = -1;
        p2 = scl2;
        while (!done2 && c < 8000) begin
            tick();
            c++;
            if (scl2 && !p2) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            p2 = scl2;
        end
        chk("scl_period", r2 - r1, 4 * QD2);
        chk("done2_cyc", c, (2 + 36 + 3) * QD2 + 1);
        chk("ack_err2", ack_err2, 1);
        tick();
        chk("idle_gap", ready2, 1);
        chk("idle_done2", done2, 0);
        tick();
        chk("b2b_accept", ready2, 0);
        start2 = 1'b0;
        c = 1;
        while (!done2 && c < 8000) begin tick(); c++; end
        chk("done2_cyc_b", c, (2 + 36 + 3) * QD2 + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
